// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NR_READ combinational read ports,
// two write-back ports (port 1 has priority) and a per-register busy
// scoreboard driven by issue (set) and write-back (clear).
// Register 0 reads as zero, is never written and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wen0,
  input  logic [ADDR_WIDTH-1:0]            waddr0,
  input  logic [DATA_WIDTH-1:0]            wdata0,
  input  logic                             wen1,
  input  logic [ADDR_WIDTH-1:0]            waddr1,
  input  logic [DATA_WIDTH-1:0]            wdata1,
  input  logic [NR_READ*ADDR_WIDTH-1:0]    raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]    rdata,
  output logic [NR_READ-1:0]               rbusy,
  input  logic                             issue_valid,
  input  logic [ADDR_WIDTH-1:0]            issue_rd,
  output logic                             issue_ready,
  output logic [(2**ADDR_WIDTH)-1:0]       busy_vec
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]       busy;

  logic w0_act;
  logic w1_act;
  logic issue_fire;

  assign w0_act     = wen0 && (waddr0 != '0);
  assign w1_act     = wen1 && (waddr1 != '0);
  assign issue_fire = issue_valid && issue_ready && (issue_rd != '0);
  assign busy_vec   = busy;

  // Issue may proceed when the destination is free now or is being freed this cycle.
  always_comb begin
    issue_ready = 1'b0;
    if (issue_rd == '0)
      issue_ready = 1'b1;
    else if (!busy[issue_rd])
      issue_ready = 1'b1;
    else if ((w0_act && (waddr0 == issue_rd)) || (w1_act && (waddr1 == issue_rd)))
      issue_ready = 1'b1;
  end

  // Register and scoreboard update; port 1 after port 0 so it wins, issue last so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf   <= '{default: '0};
      busy <= '0;
    end else begin
      if (w0_act) begin
        rf[waddr0]   <= wdata0;
        busy[waddr0] <= 1'b0;
      end
      if (w1_act) begin
        rf[waddr1]   <= wdata1;
        busy[waddr1] <= 1'b0;
      end
      if (issue_fire)
        busy[issue_rd] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NR_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

    // Operand read: zero register, stored value, optionally overridden by same-cycle write-back.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (ra != '0) begin
        rd = rf[ra];
        rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (w1_act && (waddr1 == ra)) begin
          rd = wdata1;
          rb = 1'b0;
        end else if (w0_act && (waddr0 == ra)) begin
          rd = wdata0;
          rb = 1'b0;
        end
`endif
      end
    end

    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[g]                          = rb;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb. A behavioural model of the
// register file and busy bits produces expected read results, which are
// queued when stimulus is applied and popped when the outputs are sampled.
module tb_regfile_sb;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 2;
  localparam int NREG = 2 ** AW;

  logic              clk;
  logic              rst_n;
  logic              wen0, wen1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_ready;
  logic [NREG-1:0]   busy_vec;

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          bsy;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mrf [NREG];
  logic [NREG-1:0] mbusy;
  int checks   = 0;
  int failures = 0;

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) mrf[i] = '0;
    mbusy = '0;
  endfunction

  function automatic logic model_ready();
    if (issue_rd == 0) return 1'b1;
    if (!mbusy[issue_rd]) return 1'b1;
    if (wen0 && waddr0 == issue_rd) return 1'b1;
    if (wen1 && waddr1 == issue_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model_read(input logic [AW-1:0] a);
    exp_t e;
    e.data = (a == 0) ? '0 : mrf[a];
    e.bsy  = (a == 0) ? 1'b0 : mbusy[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0) begin
      if (wen1 && waddr1 == a) begin e.data = wdata1; e.bsy = 1'b0; end
      else if (wen0 && waddr0 == a) begin e.data = wdata0; e.bsy = 1'b0; end
    end
`endif
    return e;
  endfunction

  function automatic void push_reads();
    for (int p = 0; p < NR; p++) q.push_back(model_read(raddr[p*AW +: AW]));
  endfunction

  // One clock edge; the model follows the inputs that were stable at the edge.
  task automatic tick();
    logic rdy;
    rdy = model_ready();
    @(posedge clk);
    if (rst_n) begin
      if (wen0 && waddr0 != 0) begin mrf[waddr0] = wdata0; mbusy[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 0) begin mrf[waddr1] = wdata1; mbusy[waddr1] = 1'b0; end
      if (issue_valid && rdy && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    issue_valid = 0; issue_rd = '0; raddr = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    rst_n = 0;
    model_clear();
    tick(); tick();
    rst_n = 1;
    #1;
    checks++;
    if (busy_vec !== '0) begin failures++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec); end
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
    for (int r = 0; r < NREG; r++) begin
      raddr = {AW'(r), AW'(r)};
      #1;
      push_reads();
      for (int p = 0; p < NR; p++) begin
        e = q.pop_front();
        checks++;
        if (rdata[p*DW +: DW] !== e.data || rbusy[p] !== e.bsy || e.data !== '0)
          begin failures++; $display("FAIL reset_read x%0d port%0d: got %h/%b expected 0/0", r, p, rdata[p*DW +: DW], rbusy[p]); end
      end
    end
  endtask

  task automatic test_zero_write();
    idle_inputs();
    wen0 = 1; waddr0 = '0; wdata0 = 32'hDEADBEEF;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rdata[0 +: DW] !== '0) begin failures++; $display("FAIL x0_read: got %h expected 0", rdata[0 +: DW]); end
    checks++;
    if (busy_vec[0] !== 1'b0) begin failures++; $display("FAIL x0_busy: got %b expected 0", busy_vec[0]); end
  endtask

  task automatic test_bypass();
    exp_t e;
    idle_inputs();
    issue_valid = 1; issue_rd = 5;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL issue5_ready: got %b expected 1", issue_ready); end
    tick();
    idle_inputs();
    raddr = {AW'(0), AW'(5)};
    wen1 = 1; waddr1 = 5; wdata1 = 32'h1234;
    #1;
    push_reads();
    e = q.pop_front(); void'(q.pop_front());
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (e.data !== 32'h1234 || e.bsy !== 1'b0) begin failures++; $display("FAIL bypass_model: got %h/%b expected 1234/0", e.data, e.bsy); end
`else
    checks++;
    if (e.bsy !== 1'b1) begin failures++; $display("FAIL nobypass_model: got busy %b expected 1", e.bsy); end
`endif
    checks++;
    if (rdata[0 +: DW] !== e.data || rbusy[0] !== e.bsy)
      begin failures++; $display("FAIL wb_same_cycle: got %h/%b expected %h/%b", rdata[0 +: DW], rbusy[0], e.data, e.bsy); end
    tick();
    wen1 = 0;
    #1;
    push_reads();
    e = q.pop_front(); void'(q.pop_front());
    checks++;
    if (rdata[0 +: DW] !== 32'h1234 || rbusy[0] !== 1'b0 || e.data !== 32'h1234)
      begin failures++; $display("FAIL wb_next_cycle: got %h/%b expected 00001234/0", rdata[0 +: DW], rbusy[0]); end
  endtask

  task automatic test_dual_write();
    idle_inputs();
    wen0 = 1; waddr0 = 7; wdata0 = 32'hAAAA;
    wen1 = 1; waddr1 = 7; wdata1 = 32'h5555;
    tick();
    idle_inputs();
    raddr = {AW'(7), AW'(7)};
    #1;
    checks++;
    if (rdata[DW +: DW] !== 32'h5555) begin failures++; $display("FAIL dual_write: got %h expected 00005555", rdata[DW +: DW]); end
  endtask

  task automatic test_waw();
    idle_inputs();
    issue_valid = 1; issue_rd = 3;
    tick();
    #1;
    checks++;
    if (issue_ready !== 1'b0 || model_ready() !== 1'b0) begin failures++; $display("FAIL waw_stall: got %b expected 0", issue_ready); end
    tick();
    checks++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_stall_hold: got %b expected 0", issue_ready); end
    wen0 = 1; waddr0 = 3; wdata0 = 32'h77;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL waw_release: got %b expected 1", issue_ready); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy_vec[3] !== 1'b1 || busy_vec !== mbusy) begin failures++; $display("FAIL set_wins: got %h expected %h", busy_vec, mbusy); end
    wen1 = 1; waddr1 = 3; wdata1 = 32'h78;
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    wen0 = 1; waddr0 = 9; wdata0 = 32'h99;
    tick();
    idle_inputs();
    issue_valid = 1; issue_rd = 9;
    tick();
    idle_inputs();
    raddr = {AW'(0), AW'(9)};
    #1;
    checks++;
    if (busy_vec[9] !== 1'b1 || rdata[0 +: DW] !== 32'h99) begin failures++; $display("FAIL pre_reset_x9: got %h/%b expected 00000099/1", rdata[0 +: DW], busy_vec[9]); end
    #1;
    rst_n = 0;
    model_clear();
    #1;
    checks++;
    if (busy_vec !== '0) begin failures++; $display("FAIL async_busy: got %h expected 0", busy_vec); end
    checks++;
    if (rdata[0 +: DW] !== '0) begin failures++; $display("FAIL async_x9: got %h expected 0", rdata[0 +: DW]); end
    wen0 = 1; waddr0 = 4; wdata0 = 32'h44;
    tick();
    idle_inputs();
    rst_n = 1;
    raddr = {AW'(4), AW'(4)};
    #1;
    checks++;
    if (rdata[0 +: DW] !== '0) begin failures++; $display("FAIL wb_during_reset: got %h expected 0", rdata[0 +: DW]); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 80; c++) begin
      wen0 = 1'($urandom_range(0, 1)); waddr0 = AW'($urandom_range(0, 7)); wdata0 = $urandom;
      wen1 = 1'($urandom_range(0, 1)); waddr1 = AW'($urandom_range(0, 7)); wdata1 = $urandom;
      issue_valid = 1'($urandom_range(0, 1)); issue_rd = AW'($urandom_range(0, 7));
      raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      #2;
      push_reads();
      for (int p = 0; p < NR; p++) begin
        e = q.pop_front();
        checks++;
        if (rdata[p*DW +: DW] !== e.data || rbusy[p] !== e.bsy)
          begin failures++; $display("FAIL b2b_read c%0d port%0d: got %h/%b expected %h/%b", c, p, rdata[p*DW +: DW], rbusy[p], e.data, e.bsy); end
      end
      checks++;
      if (issue_ready !== model_ready()) begin failures++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, issue_ready, model_ready()); end
      checks++;
      if (busy_vec !== mbusy) begin failures++; $display("FAIL b2b_busy c%0d: got %h expected %h", c, busy_vec, mbusy); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    model_clear();
    #1;
    test_reset();
    test_zero_write();
    test_bypass();
    test_dual_write();
    test_waw();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a configurable number of read ports, two write-back ports, and a per-register busy scoreboard. It sits in the NPC decode/write-back path. Decode reads operands and learns whether each operand is still pending. Issue marks a destination register busy. The execute and load paths write results back and clear the busy flag. Register 0 reads as zero, is never written, and is never busy.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; the block holds 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- NR_READ, 2, number of read ports, legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wen0 / waddr0 / wdata0  in  1 / ADDR_WIDTH / DATA_WIDTH  write-back port 0 (ALU path).
- wen1 / waddr1 / wdata1  in  1 / ADDR_WIDTH / DATA_WIDTH  write-back port 1 (load/multi-cycle path); wins conflicts with port 0.
- raddr  in  NR_READ*ADDR_WIDTH  packed read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR_READ*DATA_WIDTH  packed read data, same packing.
- rbusy  out  NR_READ  per-port flag: the operand is still pending.
- issue_valid  in  1  request to mark issue_rd busy.
- issue_rd  in  ADDR_WIDTH  destination register of the instruction being issued.
- issue_ready  out  1  the issue request can be accepted this cycle.
- busy_vec  out  2**ADDR_WIDTH  raw scoreboard, for debug and difftest.

## Operation
- Storage: rf[0..2**ADDR_WIDTH-1] and busy[0..2**ADDR_WIDTH-1]. On rst_n low, every rf entry and every busy bit is cleared immediately.
- Write: at the rising edge, when wenK is high and waddrK != 0, rf[waddrK] <= wdataK and busy[waddrK] <= 0.
- Dual-write conflict: if both ports are enabled with the same nonzero address, port 1's data is stored.
- Read: rdata[i] is 0 when raddr[i] == 0, otherwise rf[raddr[i]]. The path is combinational; the bypass option below modifies it.
- rbusy[i] = busy[raddr[i]]. It is 0 for address 0. The bypass option below modifies it.
- Issue handshake:
  - issue_ready = 1 when issue_rd == 0, when busy[issue_rd] == 0, or when any enabled write port targets issue_rd in this cycle.
  - The handshake completes when issue_valid && issue_ready. Then busy[issue_rd] <= 1 at the edge, unless issue_rd == 0.
- Write-after-write: issuing to a busy register stalls (issue_ready = 0) until its write-back arrives.
- Simultaneous events on one register: issue and write-back in the same cycle leave busy = 1 (set wins) and rf is updated. The new producer owns the register.
- Reset mid-operation: all pending busy bits are dropped, and any write-back arriving in the same cycle as reset is discarded.

## Timing
- Read latency is 0 cycles (combinational); write latency is 1 edge.
- issue_ready is combinational from issue_rd, busy, wenK and waddrK. It does not depend on issue_valid.
- busy_vec reflects registered state only and carries no same-cycle forwarding.
- Reset values: rdata = 0 and rbusy = 0 for all ports, busy_vec = 0, and issue_ready = 1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches an enabled nonzero write address this cycle returns that write data (port 1 priority) and drives rbusy[i] = 0.
  - A consumer may therefore issue in the same cycle as the write-back.
- REGFILE_BYPASS_EN undefined:
  - Reads return the pre-edge rf value, and rbusy[i] stays 1 until the cycle after write-back.
  - Consumers wait one extra cycle. issue_ready behaviour is unchanged.

## Test plan
- Reset, then read every register on all ports -> rdata = 0, rbusy = 0, busy_vec = 0, issue_ready = 1.
- wen0=1, waddr0=0, wdata0=0xDEADBEEF, then read raddr 0 -> rdata = 0; busy_vec[0] stays 0.
- Issue rd=5, then with wen1=1, waddr1=5, wdata1=0x1234, read port 0 at address 5 the same cycle:
  - with REGFILE_BYPASS_EN: rdata = 0x1234 and rbusy = 0;
  - without it: old value and rbusy = 1, then 0x1234 and rbusy = 0 on the next cycle.
- wen0 and wen1 both target x7 with 0xAAAA / 0x5555 -> x7 reads 0x5555 after the edge.
- Issue rd=3, then issue rd=3 again with no write-back -> issue_ready = 0. A write-back to x3 arrives with issue_valid still high -> issue_ready = 1 and busy[3] remains 1 after the edge.
- busy[9]=1, drop rst_n asynchronously between edges -> busy_vec = 0 and x9 = 0 before the next clk edge.
